// File: rtl/hist_pkg.sv
// Shared definitions for the histogram statistics controller:
// FSM state encoding, flush length and the saturating bin increment.
package hist_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_READOUT = 3'd4
    } hist_state_t;

    // Cycles spent draining the read-modify-write pipe before readout.
    localparam int unsigned FLUSH_CYCLES = 2;

    // Increment that sticks at the all-ones value of a 'width'-bit counter.
    // Works on a 32-bit carrier so it can serve any bin width up to 32;
    // callers cast the result back down to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input int unsigned width);
        logic [31:0] max_val;
        if (width >= 32)
            max_val = '1;
        else
            max_val = (32'd1 << width) - 32'd1;
        sat_inc = (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/hist_rmw_pipe.sv
// Two-stage read-modify-write pipe for bin accumulation.
// Stage0 issues the RAM read for the incoming pixel; stage1 adds one to the
// returned count (or to the value just written, when the same bin was hit
// on the previous cycle) and writes it back through port B.
module hist_rmw_pipe #(
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_DATA_WIDTH = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_pix_valid,
    input  logic [C_ADDR_WIDTH-1:0] i_pix_gray,
    output logic [C_ADDR_WIDTH-1:0] o_rd_addr,
    input  logic [C_DATA_WIDTH-1:0] i_rd_data,
    output logic                    o_wr_en,
    output logic [C_ADDR_WIDTH-1:0] o_wr_addr,
    output logic [C_DATA_WIDTH-1:0] o_wr_data
);
    import hist_pkg::*;

    logic                    r_s1_valid;
    logic [C_ADDR_WIDTH-1:0] r_s1_addr;
    logic                    r_wr_valid;
    logic [C_ADDR_WIDTH-1:0] r_wr_addr;
    logic [C_DATA_WIDTH-1:0] r_wr_data;

    logic                    w_fwd;
    logic [C_DATA_WIDTH-1:0] w_base;
    logic [C_DATA_WIDTH-1:0] w_new;

    assign o_rd_addr = i_pix_valid ? i_pix_gray : '0;

    // The RAM read returns pre-write data when the previous pixel hit the
    // same bin, so the last written value is used instead. A write from two
    // pixels back has already landed, so one entry of history is enough.
    assign w_fwd  = r_wr_valid && (r_wr_addr == r_s1_addr);
    assign w_base = w_fwd ? r_wr_data : i_rd_data;
    assign w_new  = C_DATA_WIDTH'(sat_inc(32'(w_base), C_DATA_WIDTH));

    assign o_wr_en   = r_s1_valid;
    assign o_wr_addr = r_s1_addr;
    assign o_wr_data = w_new;

    // Stage0 -> stage1: remember which bin was read this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
        end else begin
            r_s1_valid <= i_pix_valid;
            r_s1_addr  <= i_pix_gray;
        end
    end

    // Record the write just issued; a bubble in stage1 drops the history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_valid <= r_s1_valid;
            r_wr_addr  <= r_s1_addr;
            r_wr_data  <= w_new;
        end
    end

endmodule

// File: rtl/ram_dual_port.sv
// Dual-port histogram RAM with registered reads (1-cycle latency).
// A read that coincides with a write to the same address returns the old
// contents. Both ports are written from one process, so the model expects
// clk_a and clk_b to be the same clock.
module ram_dual_port #(
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_DATA_WIDTH = 20
) (
    input  logic                    clk_a,
    input  logic                    wren_a,
    input  logic [C_ADDR_WIDTH-1:0] addr_a,
    input  logic [C_DATA_WIDTH-1:0] din_a,
    output logic [C_DATA_WIDTH-1:0] dout_a,
    input  logic                    clk_b,
    input  logic                    wren_b,
    input  logic [C_ADDR_WIDTH-1:0] addr_b,
    input  logic [C_DATA_WIDTH-1:0] din_b,
    output logic [C_DATA_WIDTH-1:0] dout_b
);

    logic [C_DATA_WIDTH-1:0] r_mem [0:(1<<C_ADDR_WIDTH)-1];

    // Memory writes for both ports plus the port A registered read.
    always_ff @(posedge clk_a) begin
        if (wren_a)
            r_mem[addr_a] <= din_a;
        if (wren_b)
            r_mem[addr_b] <= din_b;
        dout_a <= r_mem[addr_a];
    end

    // Port B registered read.
    always_ff @(posedge clk_b) begin
        dout_b <= r_mem[addr_b];
    end

endmodule

// File: rtl/hist_stat_ctrl.sv
// Histogram statistics controller: clears the histogram RAM after reset,
// accumulates one gray-level histogram per frame and streams the bins out
// (clearing each one) after the frame ends.
//
// state   | meaning
// --------+--------------------------------------------------------------
// CLEAR   | sweep ptr 0..N-1 writing zero to every bin
// IDLE    | wait for a vsync rising edge
// ACCUM   | count pixels through the read-modify-write pipe
// FLUSH   | let the last pipe write land, no new reads
// READOUT | read bin k at ptr=k, present and clear it at ptr=k+1
module hist_stat_ctrl #(
    parameter int C_ADDR_WIDTH = 8,
    parameter int C_DATA_WIDTH = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    per_frame_vsync,
    input  logic                    per_frame_href,
    input  logic [C_ADDR_WIDTH-1:0] per_img_gray,
    output logic                    ram_wren_a,
    output logic [C_ADDR_WIDTH-1:0] ram_addr_a,
    output logic [C_DATA_WIDTH-1:0] ram_din_a,
    input  logic [C_DATA_WIDTH-1:0] ram_dout_a,
    output logic                    ram_wren_b,
    output logic [C_ADDR_WIDTH-1:0] ram_addr_b,
    output logic [C_DATA_WIDTH-1:0] ram_din_b,
    output logic                    hist_valid,
    output logic [C_ADDR_WIDTH-1:0] hist_bin,
    output logic [C_DATA_WIDTH-1:0] hist_count,
    output logic                    hist_done,
    output logic                    busy,
    output logic                    frame_drop
);
    import hist_pkg::*;

    localparam int unsigned C_N = 1 << C_ADDR_WIDTH;
    localparam logic [C_ADDR_WIDTH:0] C_PTR_LAST  = (C_ADDR_WIDTH+1)'(C_N - 1);
    localparam logic [C_ADDR_WIDTH:0] C_PTR_END   = (C_ADDR_WIDTH+1)'(C_N);
    localparam logic [C_ADDR_WIDTH:0] C_PTR_FLUSH = (C_ADDR_WIDTH+1)'(FLUSH_CYCLES - 1);
    localparam logic [C_ADDR_WIDTH:0] C_PTR_ONE   = (C_ADDR_WIDTH+1)'(1);

    hist_state_t             r_state;
    hist_state_t             w_state_nxt;
    logic [C_ADDR_WIDTH:0]   r_ptr;
    logic [C_ADDR_WIDTH:0]   w_ptr_nxt;
    logic                    r_vsync;

    logic                    w_vs_rise;
    logic                    w_vs_fall;
    logic                    w_pix_valid;
    logic [C_ADDR_WIDTH-1:0] w_rd_bin;

    logic [C_ADDR_WIDTH-1:0] w_pipe_rd_addr;
    logic                    w_pipe_wr_en;
    logic [C_ADDR_WIDTH-1:0] w_pipe_wr_addr;
    logic [C_DATA_WIDTH-1:0] w_pipe_wr_data;

    logic [C_ADDR_WIDTH-1:0] w_addr_a;
    logic                    w_wren_b;
    logic [C_ADDR_WIDTH-1:0] w_addr_b;
    logic [C_DATA_WIDTH-1:0] w_din_b;
    logic                    w_hist_valid;
    logic [C_ADDR_WIDTH-1:0] w_hist_bin;
    logic [C_DATA_WIDTH-1:0] w_hist_count;
    logic                    w_hist_done;
    logic                    w_busy;
    logic                    w_frame_drop;

    assign w_vs_rise   = per_frame_vsync & ~r_vsync;
    assign w_vs_fall   = ~per_frame_vsync & r_vsync;
    assign w_pix_valid = (r_state == ST_ACCUM) && per_frame_vsync && per_frame_href;

    // In READOUT the bin presented lags the read pointer by one; at ptr=N
    // this wraps to N-1.
    assign w_rd_bin = r_ptr[C_ADDR_WIDTH-1:0] - C_ADDR_WIDTH'(1);

    hist_rmw_pipe #(
        .C_ADDR_WIDTH (C_ADDR_WIDTH),
        .C_DATA_WIDTH (C_DATA_WIDTH)
    ) u_rmw_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_pix_valid (w_pix_valid),
        .i_pix_gray  (per_img_gray),
        .o_rd_addr   (w_pipe_rd_addr),
        .i_rd_data   (ram_dout_a),
        .o_wr_en     (w_pipe_wr_en),
        .o_wr_addr   (w_pipe_wr_addr),
        .o_wr_data   (w_pipe_wr_data)
    );

    // State, sweep pointer and vsync history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_vsync <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_vsync <= per_frame_vsync;
        end
    end

    // Next state and pointer; ptr doubles as the flush down-counter.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                if (r_ptr == C_PTR_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + C_PTR_ONE;
                end
            end
            ST_IDLE: begin
                if (w_vs_rise)
                    w_state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (w_vs_fall) begin
                    w_state_nxt = ST_FLUSH;
                    w_ptr_nxt   = C_PTR_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (r_ptr == '0) begin
                    w_state_nxt = ST_READOUT;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr - C_PTR_ONE;
                end
            end
            ST_READOUT: begin
                if (r_ptr == C_PTR_END) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt = r_ptr + C_PTR_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // RAM port steering and readout stream for the current state.
    always_comb begin
        w_addr_a     = '0;
        w_wren_b     = 1'b0;
        w_addr_b     = '0;
        w_din_b      = '0;
        w_hist_valid = 1'b0;
        w_hist_bin   = '0;
        w_hist_count = '0;
        w_hist_done  = 1'b0;
        w_busy       = 1'b0;
        w_frame_drop = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy       = 1'b1;
                w_frame_drop = w_vs_rise;
                w_wren_b     = 1'b1;
                w_addr_b     = r_ptr[C_ADDR_WIDTH-1:0];
            end
            ST_ACCUM: begin
                w_addr_a = w_pipe_rd_addr;
                w_wren_b = w_pipe_wr_en;
                w_addr_b = w_pipe_wr_addr;
                w_din_b  = w_pipe_wr_data;
            end
            ST_FLUSH: begin
                w_busy       = 1'b1;
                w_frame_drop = w_vs_rise;
                w_wren_b     = w_pipe_wr_en;
                w_addr_b     = w_pipe_wr_addr;
                w_din_b      = w_pipe_wr_data;
            end
            ST_READOUT: begin
                w_busy       = 1'b1;
                w_frame_drop = w_vs_rise;
                if (!r_ptr[C_ADDR_WIDTH])
                    w_addr_a = r_ptr[C_ADDR_WIDTH-1:0];
                if (r_ptr != '0) begin
                    w_hist_valid = 1'b1;
                    w_hist_bin   = w_rd_bin;
                    w_hist_count = ram_dout_a;
                    w_hist_done  = (r_ptr == C_PTR_END);
                    w_wren_b     = 1'b1;
                    w_addr_b     = w_rd_bin;
                end
            end
            default: ;
        endcase
    end

    // Outputs are forced low while reset is held, whatever state the
    // registers still show during that cycle.
    assign ram_wren_a = 1'b0;
    assign ram_din_a  = '0;
    assign ram_addr_a = rst_n ? w_addr_a     : '0;
    assign ram_wren_b = rst_n & w_wren_b;
    assign ram_addr_b = rst_n ? w_addr_b     : '0;
    assign ram_din_b  = rst_n ? w_din_b      : '0;
    assign hist_valid = rst_n & w_hist_valid;
    assign hist_bin   = rst_n ? w_hist_bin   : '0;
    assign hist_count = rst_n ? w_hist_count : '0;
    assign hist_done  = rst_n & w_hist_done;
    assign busy       = rst_n & w_busy;
    assign frame_drop = rst_n & w_frame_drop;

endmodule

// File: tb/tb_hist_stat_ctrl.sv
// Directed bench for hist_stat_ctrl. A 20-bit and a 4-bit instance run in
// lockstep on the same stimulus; the 4-bit one shows count saturation.
module tb_hist_stat_ctrl;

    localparam int AW  = 8;
    localparam int DW  = 20;
    localparam int DWS = 4;
    localparam int N   = 256;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync = 1'b0;
    logic          href  = 1'b0;
    logic [AW-1:0] gray  = '0;

    logic          wren_a, wren_b, hist_valid, hist_done, busy, frame_drop;
    logic [AW-1:0] addr_a, addr_b, hist_bin;
    logic [DW-1:0] din_a, din_b, dout_a, dout_b, hist_count;

    logic           wren_a_s, wren_b_s, hist_valid_s, hist_done_s, busy_s, frame_drop_s;
    logic [AW-1:0]  addr_a_s, addr_b_s, hist_bin_s;
    logic [DWS-1:0] din_a_s, din_b_s, dout_a_s, dout_b_s, hist_count_s;

    logic any_out;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_hist [N];
    int exp_s3;

    always #5 clk = ~clk;

    hist_stat_ctrl #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_img_gray(gray),
        .ram_wren_a(wren_a), .ram_addr_a(addr_a), .ram_din_a(din_a), .ram_dout_a(dout_a),
        .ram_wren_b(wren_b), .ram_addr_b(addr_b), .ram_din_b(din_b),
        .hist_valid(hist_valid), .hist_bin(hist_bin), .hist_count(hist_count),
        .hist_done(hist_done), .busy(busy), .frame_drop(frame_drop)
    );

    ram_dual_port #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) u_ram (
        .clk_a(clk), .wren_a(wren_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
        .clk_b(clk), .wren_b(wren_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b)
    );

    hist_stat_ctrl #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DWS)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(vsync), .per_frame_href(href), .per_img_gray(gray),
        .ram_wren_a(wren_a_s), .ram_addr_a(addr_a_s), .ram_din_a(din_a_s), .ram_dout_a(dout_a_s),
        .ram_wren_b(wren_b_s), .ram_addr_b(addr_b_s), .ram_din_b(din_b_s),
        .hist_valid(hist_valid_s), .hist_bin(hist_bin_s), .hist_count(hist_count_s),
        .hist_done(hist_done_s), .busy(busy_s), .frame_drop(frame_drop_s)
    );

    ram_dual_port #(.C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DWS)) u_ram_s (
        .clk_a(clk), .wren_a(wren_a_s), .addr_a(addr_a_s), .din_a(din_a_s), .dout_a(dout_a_s),
        .clk_b(clk), .wren_b(wren_b_s), .addr_b(addr_b_s), .din_b(din_b_s), .dout_b(dout_b_s)
    );

    assign any_out = wren_a | (|addr_a) | (|din_a) | wren_b | (|addr_b) | (|din_b) |
                     hist_valid | (|hist_bin) | (|hist_count) | hist_done | busy | frame_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One input cycle: values change just after the rising edge.
    task automatic drive(input int vs, input int hr, input int g);
        @(posedge clk);
        #1;
        vsync = (vs != 0);
        href  = (hr != 0);
        gray  = AW'(g);
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) exp_hist[i] = 0;
        exp_s3 = -1;
    endtask

    // Called right after reset release: expect the N-cycle zeroing sweep.
    task automatic check_clear(input string tag);
        int errs = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check({tag, "_clr_first_wren"}, 32'(wren_b), 32'd1);
                check({tag, "_clr_first_busy"}, 32'(busy), 32'd1);
            end
            if (wren_b !== 1'b1 || addr_b !== AW'(k) || din_b !== '0 ||
                busy !== 1'b1 || wren_a !== 1'b0)
                errs++;
        end
        check({tag, "_clr_sweep_errs"}, 32'(errs), 32'd0);
        @(negedge clk);
        check({tag, "_clr_end_busy"}, 32'(busy), 32'd0);
        check({tag, "_clr_end_wren"}, 32'(wren_b), 32'd0);
    endtask

    // Called right after the vsync-fall cycle is driven.
    task automatic check_readout(input string tag);
        int waited   = 0;
        int seq_err  = 0;
        int done_err = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!hist_valid && waited < 300);
        check({tag, "_first_bin_latency"}, 32'(waited), 32'd5);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge clk);
            if (hist_valid !== 1'b1 || hist_bin !== AW'(k)) seq_err++;
            if (wren_b !== 1'b1 || addr_b !== AW'(k) || din_b !== '0) seq_err++;
            if (hist_done !== (k == N - 1)) done_err++;
            check($sformatf("%s_bin%0d", tag, k), 32'(hist_count), exp_hist[k]);
            if (k == 3 && exp_s3 >= 0)
                check({tag, "_sat_bin3"}, 32'(hist_count_s), exp_s3);
        end
        check({tag, "_seq_errs"}, 32'(seq_err), 32'd0);
        check({tag, "_done_errs"}, 32'(done_err), 32'd0);
        @(negedge clk);
        check({tag, "_after_valid"}, 32'(hist_valid), 32'd0);
        check({tag, "_after_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_tests);
        $fatal(1, "time limit");
    end

    initial begin
        clear_exp();

        // Power-on reset and clear sweep.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("por_out_zero", 32'(any_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_clear("por");

        // Gray 0..15 once each.
        clear_exp();
        for (int i = 0; i < 16; i++) exp_hist[i] = 1;
        drive(1, 0, 0);
        for (int g = 0; g < 16; g++) begin
            drive(1, 1, g);
            if (g == 5) begin
                @(negedge clk);
                check("accum_busy", 32'(busy), 32'd0);
                check("accum_rd_addr", 32'(addr_a), 32'd5);
                check("accum_wr_addr", 32'(addr_b), 32'd4);
                check("accum_wr_data", 32'(din_b), 32'd1);
                check("accum_wren_a", 32'(wren_a), 32'd0);
            end
        end
        drive(0, 0, 0);
        check_readout("ramp");

        // Same bin every cycle, then with single-cycle gaps.
        clear_exp();
        exp_hist[7] = 103;
        drive(1, 0, 0);
        repeat (100) drive(1, 1, 7);
        repeat (3) begin
            drive(1, 0, 0);
            drive(1, 1, 7);
        end
        drive(0, 0, 0);
        check_readout("fwd7");

        // Alternating bins 5 and 9.
        clear_exp();
        exp_hist[5] = 20;
        exp_hist[9] = 20;
        drive(1, 0, 0);
        for (int i = 0; i < 40; i++) drive(1, 1, (i % 2 == 0) ? 5 : 9);
        drive(0, 0, 0);
        check_readout("alt59");

        // Previous readout must have cleared bin 5.
        clear_exp();
        exp_hist[5] = 4;
        drive(1, 0, 0);
        repeat (4) drive(1, 1, 5);
        drive(0, 0, 0);
        check_readout("reread5");

        // 20 hits on bin 3: 4-bit instance sticks at 15.
        clear_exp();
        exp_hist[3] = 20;
        exp_s3 = 15;
        drive(1, 0, 0);
        repeat (20) drive(1, 1, 3);
        drive(0, 0, 0);
        check_readout("sat3");

        // Frame start during readout is dropped along with its pixels.
        clear_exp();
        exp_hist[1] = 2;
        drive(1, 0, 0);
        drive(1, 1, 1);
        drive(1, 1, 1);
        drive(0, 0, 0);
        fork
            check_readout("drop_rd");
            begin
                repeat (20) drive(0, 0, 0);
                drive(1, 0, 0);
                @(negedge clk);
                check("drop_pulse", 32'(frame_drop), 32'd1);
                drive(1, 1, 200);
                @(negedge clk);
                check("drop_pulse_width", 32'(frame_drop), 32'd0);
                repeat (300) drive(1, 1, 200);
            end
        join
        @(negedge clk);
        check("drop_idle_busy", 32'(busy), 32'd0);
        check("drop_idle_wren", 32'(wren_b), 32'd0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        clear_exp();
        exp_hist[200] = 3;
        drive(1, 0, 0);
        repeat (3) drive(1, 1, 200);
        drive(0, 0, 0);
        check_readout("after_drop");

        // One-cycle reset in the middle of a frame.
        drive(1, 0, 0);
        repeat (10) drive(1, 1, 50);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        vsync = 1'b0;
        href  = 1'b0;
        @(negedge clk);
        check("midrst_out_zero", 32'(any_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_clear("midrst");
        clear_exp();
        exp_hist[50] = 6;
        drive(1, 0, 0);
        repeat (6) drive(1, 1, 50);
        drive(0, 0, 0);
        check_readout("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hist_stat_ctrl.md
Name: hist_stat_ctrl

Overview:
- Sequences a dual-port histogram RAM (depth 2^C_ADDR_WIDTH, registered read, 1-cycle latency) for the histogram-equalization pipeline.
- Accumulates one gray-level histogram per frame: port A reads, port B writes, with read-modify-write forwarding.
- At frame end, streams all bins out to the CDF/mapping stage and clears each bin as it is read. Also clears the RAM after reset.

Parameters:
C_ADDR_WIDTH, 8, gray-level width; number of bins N = 2^C_ADDR_WIDTH
C_DATA_WIDTH, 20, bin count width; counts saturate at 2^C_DATA_WIDTH-1

Ports:
clk  in  1  single system clock
rst_n  in  1  synchronous active-low reset
per_frame_vsync  in  1  frame-valid; high for the whole frame
per_frame_href  in  1  pixel valid
per_img_gray  in  C_ADDR_WIDTH  pixel gray level
ram_wren_a  out  1  port A write enable; constant 0 (read-only use)
ram_addr_a  out  C_ADDR_WIDTH  port A read address
ram_din_a  out  C_DATA_WIDTH  constant 0
ram_dout_a  in  C_DATA_WIDTH  port A read data, valid 1 cycle after address
ram_wren_b  out  1  port B write enable
ram_addr_b  out  C_ADDR_WIDTH  port B write address
ram_din_b  out  C_DATA_WIDTH  port B write data
hist_valid  out  1  one bin presented this cycle
hist_bin  out  C_ADDR_WIDTH  bin index
hist_count  out  C_DATA_WIDTH  bin count
hist_done  out  1  1-cycle pulse with the last bin
busy  out  1  high in any state other than IDLE and ACCUM
frame_drop  out  1  1-cycle pulse when a frame start is ignored

Behaviour:
- Reset: every output is 0 and the FSM enters CLEAR. This includes reset asserted mid-frame or mid-readout; partial RAM contents are discarded.
- FSM states: CLEAR, IDLE, ACCUM, FLUSH, READOUT.
- CLEAR:
  - ptr runs 0..N-1, one per cycle: ram_wren_b=1, ram_addr_b=ptr, ram_din_b=0.
  - After ptr=N-1 -> IDLE (N cycles).
- IDLE: on vsync rising edge (registered vsync 0 -> current 1) -> ACCUM.
- ACCUM:
  - Stage0: when href=1, drive ram_addr_a=gray; register s1_valid, s1_addr.
  - Stage1 (next cycle): base = (wr_valid_q && wr_addr_q==s1_addr) ? wr_data_q : ram_dout_a.
  - new = base+1, saturating at all-ones. Write port B: wren_b=1, addr_b=s1_addr, din_b=new.
  - Latch wr_valid_q/wr_addr_q/wr_data_q for forwarding. One-deep forwarding is sufficient, because a write is committed before the read issued two pixels later.
  - Back-to-back pixels, including the same gray level every cycle, are accepted at 1 pixel/cycle with no stall.
  - href gaps insert bubbles. wr_valid_q clears on a bubble cycle.
  - href while vsync=0 is ignored.
- vsync falling edge in ACCUM -> FLUSH.
- FLUSH: 2 cycles. Completes any in-flight stage1 write. No new reads. Then -> READOUT with ptr=0.
- READOUT:
  - Cycle k (k=0..N-1): ram_addr_a=k.
  - Cycle k+1: hist_valid=1, hist_bin=k, hist_count=ram_dout_a; in the same cycle ram_wren_b=1, ram_addr_b=k, ram_din_b=0 (clear-on-read).
  - hist_done=1 together with bin N-1, then -> IDLE.
  - Total: N+1 cycles. Output is strictly consecutive, with no backpressure.
- A vsync rising edge in CLEAR, FLUSH or READOUT: frame_drop pulses 1 cycle, and that frame's pixels are ignored. The FSM does not re-arm until the next rising edge seen in IDLE.
- vsync falling in IDLE: ignored.
- Port A and port B never address the same bin in the same cycle while a read result is needed. The forwarding covers the one case where they could.
- All counters and ptr are C_ADDR_WIDTH+1 bits wide, so wrap at N-1 is detected without aliasing.

Decomposition:
- Shared package hist_pkg: FSM state encoding (CLEAR, IDLE, ACCUM, FLUSH, READOUT), FLUSH_CYCLES=2, the saturating-increment function.
- One natural sub-module: hist_rmw_pipe, the stage0/stage1 read-modify-write, forwarding and saturation. The FSM, CLEAR sweep and READOUT sweep stay in the top level.
- The bench instantiates ram_dual_port (C_ADDR_WIDTH/C_DATA_WIDTH matched, clk_a=clk_b=clk).

Test Plan:
- Reset release -> busy=1 for 256 cycles, ram_wren_b=1 with addresses 0..255 and data 0, then busy=0. Next frame readout shows all counts 0 except the frame's pixels.
- Frame of 16 pixels, gray 0..15 once each, then vsync fall -> READOUT gives hist_count=1 for bins 0..15 and 0 elsewhere; hist_done is coincident with bin 255; 257 cycles after FLUSH.
- Frame of 100 consecutive href pixels all gray=7 (forwarding stress), plus 3 pixels gray=7 with one-cycle gaps -> bin 7 = 103, all other bins 0.
- Alternating gray 5,9,5,9 for 40 cycles -> bins 5 and 9 each = 20. Second frame of 4 pixels gray=5 -> bin 5 = 4 (proves clear-on-read).
- C_DATA_WIDTH=4, 20 pixels gray=3 -> bin 3 = 15 (saturated, no wrap).
- vsync rise during READOUT -> frame_drop pulse, that frame ignored. rst_n low for 1 cycle mid-ACCUM -> all outputs 0, full CLEAR; next frame counts are correct.
